// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared constants for the hazard/stall controller
// Purpose: forwarding select encodings, divider FSM states and the r0 constant
//          shared by hazard_stall_ctrl and its forwarding mux.
// Ports:   none (package)
package hazard_stall_ctrl_pkg;

  // Operand source selects seen by the ID-stage operand muxes
  localparam logic [1:0] FWD_RF   = 2'b00;  // register file
  localparam logic [1:0] FWD_EXE  = 2'b01;  // EX-stage ALU result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MEML = 2'b11;  // MEM-stage load data

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } div_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_fwd_sel.sv
// rtl/hazard_stall_ctrl_fwd_sel.sv - forwarding priority mux for one ID operand
// Purpose: picks where one ID source operand comes from (regfile, EX ALU,
//          MEM ALU or MEM load data); the nearest producer wins.
// Ports:   src                  - ID source register number
//          ex_wreg/ex_m2reg/ex_rn    - EX-stage write enable, load flag, dest
//          mem_wreg/mem_m2reg/mem_rn - MEM-stage write enable, load flag, dest
//          fwd                  - operand select (FWD_* encoding)
module hazard_stall_ctrl_fwd_sel
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ex_wreg,
  input  logic       ex_m2reg,
  input  logic [4:0] ex_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    // r0 is hardwired zero, so a write to it must never be forwarded
    if (src != REG_ZERO) begin
      // A load still in EX has no data yet; the load-use stall covers it,
      // so only an EX ALU result is eligible here.
      if (ex_wreg && !ex_m2reg && (ex_rn == src)) begin
        fwd = FWD_EXE;
      end else if (mem_wreg && !mem_m2reg && (mem_rn == src)) begin
        fwd = FWD_MEM;
      end else if (mem_wreg && mem_m2reg && (mem_rn == src)) begin
        fwd = FWD_MEML;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - 5-stage pipeline hazard, stall and divider sequencer
// Purpose: load-use and HI/LO stall generation, operand forwarding selects,
//          taken-branch IF flush, multi-cycle divider sequencing and a
//          saturating stall-cycle counter.
// Ports:   clk, clrn (async active-low)
//          id_*     - ID-stage operand/instruction info
//          ex_*     - EX-stage writeback info
//          mem_*    - MEM-stage writeback info
//          loaddepend, id_bubble, if_flush - pipeline control
//          fwda, fwdb - rs/rt operand selects
//          div_start, div_busy, div_done - divider handshake
//          stall_cycles - saturating count of stalled cycles
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_div,
  input  logic             id_uses_hilo,
  input  logic             id_branch_taken,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic             loaddepend,
  output logic             id_bubble,
  output logic             if_flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             div_start,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

  div_state_t    state, state_nxt;
  logic [CW-1:0] div_cnt, cnt_nxt;
  logic          lu, hz;

  hazard_stall_ctrl_fwd_sel u_fwd_rs (
    .src       (id_rs),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwda)
  );

  hazard_stall_ctrl_fwd_sel u_fwd_rt (
    .src       (id_rt),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwdb)
  );

  assign div_busy = (state == S_BUSY);

  // Load in EX feeding an operand the ID instruction actually reads
  assign lu = ex_wreg && ex_m2reg && (ex_rn != REG_ZERO) &&
              ((id_use_rs && (ex_rn == id_rs)) || (id_use_rt && (ex_rn == id_rt)));

  // HI/LO are not valid until the divide completes; a second div must also
  // wait because the divider does not overlap operations.
  assign hz = div_busy && (id_uses_hilo || id_is_div);

  assign loaddepend = lu || hz;
  assign id_bubble  = loaddepend;
  // A stalled branch keeps its slot and re-resolves after the stall
  assign if_flush   = id_branch_taken && !loaddepend;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= S_IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = div_cnt;
    div_start = 1'b0;
    div_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (id_is_div && !loaddepend) begin
          div_start = 1'b1;
          state_nxt = S_BUSY;
          cnt_nxt   = CW'(DIV_LAT - 1);
        end
      end
      S_BUSY: begin
        // Counting continues regardless of load-use stalls
        if (div_cnt == '0) begin
          div_done  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = div_cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cycles <= '0;
    end else if (loaddepend && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
